// File: rtl/ballot_session_ctrl_pkg.sv
// Shared types, defaults and helpers for the ballot session controller.
package ballot_session_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_RESULT  = 2'd3
    } state_e;

    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_CONFIRM_CYCLES = 10;
    localparam int DEF_DWELL_CYCLES   = 50;

    localparam int NUM_CAND = 4;
    localparam int TALLY_W  = 8;
    localparam int SEL_W    = $clog2(NUM_CAND);
    localparam int VCNT_W   = $clog2(NUM_CAND + 1);

    // Counter width able to hold 0..N-1 for the largest of the three periods.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    function automatic logic [VCNT_W-1:0] count_votes(input logic [NUM_CAND-1:0] v);
        logic [VCNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            n = n + VCNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ballot_session_ctrl_if.sv
// Operator/panel side signals of the ballot session controller.
interface ballot_session_ctrl_if;
    import ballot_session_ctrl_pkg::*;

    logic                        mode;
    logic                        authorize;
    logic [NUM_CAND-1:0]         vote_valid;
    logic [NUM_CAND*TALLY_W-1:0] cand_counts;
    logic [NUM_CAND-1:0]         vote_commit;
    logic                        ballot_armed;
    logic                        reject_err;
    logic                        timeout_err;
    logic [SEL_W-1:0]            result_sel;
    logic [TALLY_W-1:0]          leds;

    modport master (
        output mode, authorize, vote_valid, cand_counts,
        input  vote_commit, ballot_armed, reject_err, timeout_err, result_sel, leds
    );

    modport slave (
        input  mode, authorize, vote_valid, cand_counts,
        output vote_commit, ballot_armed, reject_err, timeout_err, result_sel, leds
    );
endinterface

// File: rtl/ballot_session_ctrl_timer.sv
// Free-running 0..last_i counter with synchronous clear; tc_o marks the last count.
module cycle_timer
    import ballot_session_ctrl_pkg::*;
#(
    parameter int WIDTH = timer_width(DEF_TIMEOUT_CYCLES, DEF_CONFIRM_CYCLES, DEF_DWELL_CYCLES)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic             tc_o
);
    logic [WIDTH-1:0] count_q, count_d;

    assign tc_o = en_i && !load_i && (count_q == last_i);

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/ballot_session_ctrl.sv
// Voting booth session FSM: arms one ballot, commits a single press, shows results.
module ballot_session_ctrl
    import ballot_session_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
    parameter int DWELL_CYCLES   = DEF_DWELL_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    ballot_session_ctrl_if.slave  bus
);
    localparam int TW = timer_width(TIMEOUT_CYCLES, CONFIRM_CYCLES, DWELL_CYCLES);

    state_e              state_q;
    logic [NUM_CAND-1:0] commit_q;
    logic                armed_q;
    logic                reject_q;
    logic                timeout_q;
    logic [SEL_W-1:0]    sel_q;
    logic [TALLY_W-1:0]  leds_q;

    logic [TALLY_W-1:0]  tally [NUM_CAND];
    logic [VCNT_W-1:0]   vote_cnt;
    logic                vote_one, vote_multi;
    logic                timer_load, timer_en, timer_tc;
    logic [TW-1:0]       timer_last;

    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_tally
        assign tally[gi] = bus.cand_counts[gi*TALLY_W +: TALLY_W];
    end

    assign vote_cnt   = count_votes(bus.vote_valid);
    assign vote_one   = (vote_cnt == VCNT_W'(1));
    assign vote_multi = (vote_cnt > VCNT_W'(1));

    // Timer is held at 0 while idle and restarted on the commit edge, so every
    // phase begins its count at 0 without an explicit load from the FSM.
    assign timer_load = (state_q == ST_IDLE) || ((state_q == ST_ARMED) && vote_one);
    assign timer_en   = (state_q != ST_IDLE);

    always_comb begin
        timer_last = '0;
        case (state_q)
            ST_ARMED:   timer_last = TW'(TIMEOUT_CYCLES - 1);
            ST_CONFIRM: timer_last = TW'(CONFIRM_CYCLES - 1);
            ST_RESULT:  timer_last = TW'(DWELL_CYCLES - 1);
            default:    timer_last = '0;
        endcase
    end

    cycle_timer #(.WIDTH(TW)) u_timer (
        .clk    (clock),
        .srst   (reset),
        .load_i (timer_load),
        .en_i   (timer_en),
        .last_i (timer_last),
        .tc_o   (timer_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            commit_q  <= '0;
            armed_q   <= 1'b0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
            sel_q     <= '0;
            leds_q    <= '0;
        end else begin
            commit_q  <= '0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    leds_q   <= '0;
                    sel_q    <= '0;
                    armed_q  <= 1'b0;
                    reject_q <= |bus.vote_valid;
                    if (bus.mode) begin
                        state_q <= ST_RESULT;
                    end else if (bus.authorize) begin
                        state_q <= ST_ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // A valid press on the expiry cycle still commits.
                    if (vote_one) begin
                        commit_q <= bus.vote_valid;
                        state_q  <= ST_CONFIRM;
                        armed_q  <= 1'b0;
                        leds_q   <= {TALLY_W{1'b1}};
                    end else begin
                        reject_q <= vote_multi;
                        if (timer_tc) begin
                            timeout_q <= 1'b1;
                            state_q   <= ST_IDLE;
                            armed_q   <= 1'b0;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (timer_tc) begin
                        state_q <= ST_IDLE;
                        leds_q  <= '0;
                    end
                end
                ST_RESULT: begin
                    if (!bus.mode) begin
                        state_q <= ST_IDLE;
                        leds_q  <= '0;
                        sel_q   <= '0;
                    end else begin
                        leds_q <= tally[sel_q];
                        if (timer_tc) begin
                            sel_q <= sel_q + SEL_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.vote_commit  = commit_q;
    assign bus.ballot_armed = armed_q;
    assign bus.reject_err   = reject_q;
    assign bus.timeout_err  = timeout_q;
    assign bus.result_sel   = sel_q;
    assign bus.leds         = leds_q;
endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Bench for ballot_session_ctrl: vector table, corner sequences and a random run vs a phase/age model.
module tb_ballot_session_ctrl;
    localparam int TO = 20;
    localparam int CF = 4;
    localparam int DW = 3;
    localparam logic I = 1'b1;
    localparam logic O = 1'b0;

    typedef struct {
        logic       r, m, a;
        logic [3:0] v;
        logic [3:0] commit;
        logic       armed, rej, to;
        logic [1:0] sel;
        logic [7:0] leds;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cc;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ncyc  = 0;

    // Reference model: phase (0 idle, 1 armed, 2 confirm, 3 result) and cycles spent in it.
    int          ph  = 0;
    int          age = 0;
    logic [3:0]  m_commit;
    logic        m_armed, m_rej, m_to;
    logic [1:0]  m_sel;
    logic [7:0]  m_leds;

    ballot_session_ctrl_if bus();

    ballot_session_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CONFIRM_CYCLES (CF),
        .DWELL_CYCLES   (DW)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dut_vec();
        return 32'({bus.vote_commit, bus.ballot_armed, bus.reject_err, bus.timeout_err,
                    bus.result_sel, bus.leds});
    endfunction

    function automatic vec_t mk(input logic r, input logic m, input logic a, input logic [3:0] v,
                                input logic [3:0] c, input logic ar, input logic rj, input logic t,
                                input logic [1:0] s, input logic [7:0] l);
        vec_t x;
        x.r = r; x.m = m; x.a = a; x.v = v; x.commit = c;
        x.armed = ar; x.rej = rj; x.to = t; x.sel = s; x.leds = l;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, ncyc, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic m, input logic a, input logic [3:0] v);
        int n;
        n = $countones(v);
        m_commit = 4'h0;
        m_rej    = 1'b0;
        m_to     = 1'b0;
        if (r) begin
            ph = 0; age = 0; m_sel = 2'd0; m_leds = 8'h00;
        end else begin
            case (ph)
                0: begin
                    m_rej = (n != 0); m_leds = 8'h00; m_sel = 2'd0; age = 0;
                    if (m) ph = 3;
                    else if (a) ph = 1;
                end
                1: begin
                    if (n == 1) begin
                        m_commit = v; ph = 2; age = 0; m_leds = 8'hFF;
                    end else begin
                        m_rej = (n > 1);
                        if (age == TO - 1) begin
                            m_to = 1'b1; ph = 0;
                        end else begin
                            age++;
                        end
                    end
                end
                2: begin
                    if (age == CF - 1) begin
                        ph = 0; m_leds = 8'h00;
                    end else begin
                        age++;
                    end
                end
                default: begin
                    if (!m) begin
                        ph = 0; m_leds = 8'h00; m_sel = 2'd0;
                    end else begin
                        m_leds = cc[8*((age / DW) % 4) +: 8];
                        age++;
                        m_sel = 2'((age / DW) % 4);
                    end
                end
            endcase
        end
        m_armed = (ph == 1);
    endtask

    task automatic cyc(input logic r, input logic m, input logic a, input logic [3:0] v);
        rst             = r;
        bus.mode        = m;
        bus.authorize   = a;
        bus.vote_valid  = v;
        bus.cand_counts = cc;
        model_step(r, m, a, v);
        @(posedge clk);
        #1;
        ncyc++;
        $display("cyc %0d rst=%b mode=%b auth=%b vote=%b -> commit=%b armed=%b rej=%b to=%b sel=%0d leds=%h",
                 ncyc, r, m, a, v, bus.vote_commit, bus.ballot_armed, bus.reject_err,
                 bus.timeout_err, bus.result_sel, bus.leds);
        chk("model", dut_vec(),
            32'({m_commit, m_armed, m_rej, m_to, m_sel, m_leds}));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(O, O, O, 4'h0);
    endtask

    vec_t       tbl [19];
    logic [7:0] scan_exp [13];

    initial begin
        rst = 1'b1;
        cc  = 32'h0;
        bus.mode = 1'b0; bus.authorize = 1'b0; bus.vote_valid = 4'h0; bus.cand_counts = 32'h0;

        //           r  m  a  vote      commit   ar rj to sel   leds
        tbl[0]  = mk(I, O, O, 4'b0000, 4'b0000, O, O, O, 2'd0, 8'h00);
        tbl[1]  = mk(O, O, I, 4'b0000, 4'b0000, I, O, O, 2'd0, 8'h00);
        tbl[2]  = mk(O, O, O, 4'b0000, 4'b0000, I, O, O, 2'd0, 8'h00);
        tbl[3]  = mk(O, O, O, 4'b0000, 4'b0000, I, O, O, 2'd0, 8'h00);
        tbl[4]  = mk(O, O, O, 4'b0010, 4'b0010, O, O, O, 2'd0, 8'hFF);
        tbl[5]  = mk(O, O, O, 4'b0001, 4'b0000, O, O, O, 2'd0, 8'hFF);
        tbl[6]  = mk(O, O, O, 4'b0000, 4'b0000, O, O, O, 2'd0, 8'hFF);
        tbl[7]  = mk(O, O, O, 4'b0000, 4'b0000, O, O, O, 2'd0, 8'hFF);
        tbl[8]  = mk(O, O, O, 4'b0000, 4'b0000, O, O, O, 2'd0, 8'h00);
        tbl[9]  = mk(O, O, O, 4'b0001, 4'b0000, O, I, O, 2'd0, 8'h00);
        tbl[10] = mk(O, O, I, 4'b0000, 4'b0000, I, O, O, 2'd0, 8'h00);
        tbl[11] = mk(O, O, O, 4'b0101, 4'b0000, I, I, O, 2'd0, 8'h00);
        tbl[12] = mk(O, O, O, 4'b1000, 4'b1000, O, O, O, 2'd0, 8'hFF);
        tbl[13] = mk(O, I, I, 4'b0000, 4'b0000, O, O, O, 2'd0, 8'hFF);
        tbl[14] = mk(O, I, O, 4'b0100, 4'b0000, O, O, O, 2'd0, 8'hFF);
        tbl[15] = mk(O, I, O, 4'b0000, 4'b0000, O, O, O, 2'd0, 8'hFF);
        tbl[16] = mk(O, I, O, 4'b0000, 4'b0000, O, O, O, 2'd0, 8'h00);
        tbl[17] = mk(O, I, I, 4'b0000, 4'b0000, O, O, O, 2'd0, 8'h00);
        tbl[18] = mk(O, O, O, 4'b0000, 4'b0000, O, O, O, 2'd0, 8'h00);

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].r, tbl[i].m, tbl[i].a, tbl[i].v);
            chk($sformatf("tbl%0d", i), dut_vec(),
                32'({tbl[i].commit, tbl[i].armed, tbl[i].rej, tbl[i].to, tbl[i].sel, tbl[i].leds}));
        end

        // Timeout exactly TO cycles after entering ARMED.
        cyc(I, O, O, 4'h0);
        cyc(O, O, I, 4'h0);
        chk("arm", 32'(bus.ballot_armed), 32'd1);
        for (int k = 1; k < TO; k++) begin
            cyc(O, O, O, 4'h0);
            chk("to_wait", 32'({bus.ballot_armed, bus.timeout_err}), 32'b10);
        end
        cyc(O, O, O, 4'h0);
        chk("timeout", 32'({bus.ballot_armed, bus.timeout_err}), 32'b01);
        cyc(O, O, O, 4'h0);
        chk("to_pulse", 32'(bus.timeout_err), 32'd0);

        // Vote in the final ARMED cycle beats the timeout.
        cyc(O, O, I, 4'h0);
        idle(TO - 1);
        cyc(O, O, O, 4'b0100);
        chk("late_vote", 32'({bus.vote_commit, bus.timeout_err}), 32'({4'b0100, 1'b0}));
        idle(CF + 1);

        // Result scan with presses ignored.
        cc = 32'h04_03_02_01;
        scan_exp = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03,
                     8'h03, 8'h03, 8'h04, 8'h04, 8'h04, 8'h01};
        cyc(O, I, O, 4'h0);
        chk("scan_entry", 32'({bus.result_sel, bus.leds}), 32'h0);
        for (int i = 0; i < 13; i++) begin
            cyc(O, I, O, (i % 3 == 1) ? 4'b0011 : 4'b0000);
            chk($sformatf("scan%0d", i), 32'({bus.reject_err, bus.leds}), 32'({1'b0, scan_exp[i]}));
        end
        cyc(O, O, O, 4'h0);
        chk("scan_exit", 32'({bus.result_sel, bus.leds}), 32'h0);

        // Reset mid-CONFIRM, with a pending press, and mid-scan.
        cyc(O, O, I, 4'h0);
        cyc(O, O, O, 4'b0001);
        cyc(O, O, O, 4'h0);
        cyc(I, O, O, 4'h0);
        chk("rst_confirm", dut_vec(), 32'h0);
        cyc(O, O, I, 4'h0);
        chk("rst_to_idle", 32'(bus.ballot_armed), 32'd1);
        cyc(I, O, O, 4'b0010);
        chk("rst_discard", dut_vec(), 32'h0);
        for (int i = 0; i < 5; i++) cyc(O, I, O, 4'h0);
        cyc(I, I, O, 4'h0);
        chk("rst_scan", dut_vec(), 32'h0);
        cyc(O, O, I, 4'h0);
        chk("rst_scan_idle", 32'(bus.ballot_armed), 32'd1);

        // Randomized run against the model.
        begin
            logic rm;
            rm = 1'b0;
            cyc(I, O, O, 4'h0);
            for (int n = 0; n < 1500; n++) begin
                int         k;
                logic       r, a;
                logic [3:0] v;
                k = $urandom_range(0, 19);
                if (k < 14)      v = 4'h0;
                else if (k < 18) v = 4'(1 << $urandom_range(0, 3));
                else             v = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 24) == 0) rm = ~rm;
                if ($urandom_range(0, 49) == 0) cc = $urandom;
                r = ($urandom_range(0, 99) == 0);
                a = ($urandom_range(0, 3) == 0);
                cyc(r, rm, a, v);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ballot_session_ctrl.md
BALLOT_SESSION_CTRL -- requirements
Module: ballot_session_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the maximum cycles an armed ballot waits for a vote.
REQ-002 The module SHALL have parameter CONFIRM_CYCLES, default 10, giving the cycles the confirm lamp is held after a committed vote.
REQ-003 The module SHALL have parameter DWELL_CYCLES, default 50, giving the cycles each candidate count is shown in result scan.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port mode, input, 1 bit: 0 = voting, 1 = result display.
REQ-007 The module SHALL have port authorize, input, 1 bit: officer request to arm one ballot.
REQ-008 The module SHALL have port vote_valid, input, 4 bits: one-cycle debounced press pulses; bit i = candidate i+1.
REQ-009 The module SHALL have port cand_counts, input, 32 bits: packed tallies, bits [8i+7:8i] = candidate i+1.
REQ-010 The module SHALL have port vote_commit, output, 4 bits: one-hot, one-cycle pulse to the tally logger.
REQ-011 The module SHALL have port ballot_armed, output, 1 bit: high in ARMED.
REQ-012 The module SHALL have port reject_err, output, 1 bit: one-cycle pulse on an illegal press.
REQ-013 The module SHALL have port timeout_err, output, 1 bit: one-cycle pulse on ballot expiry.
REQ-014 The module SHALL have port result_sel, output, 2 bits: index of the candidate currently displayed.
REQ-015 The module SHALL have port leds, output, 8 bits: display value.

Function
REQ-016 The FSM SHALL have states IDLE, ARMED, CONFIRM and RESULT; all outputs SHALL be registered.
REQ-017 In IDLE, the FSM SHALL go to RESULT if mode=1; else to ARMED if authorize=1; mode SHALL take priority.
REQ-018 In IDLE, any nonzero vote_valid SHALL pulse reject_err the next cycle, with no commit.
REQ-019 In ARMED with exactly one vote_valid bit set, the FSM SHALL pulse vote_commit with that bit on the next cycle and enter CONFIRM.
REQ-020 In ARMED with two or more vote_valid bits set in the same cycle, the FSM SHALL pulse reject_err, SHALL NOT commit, and SHALL remain ARMED with the timer not restarted.
REQ-021 In ARMED with no vote, after TIMEOUT_CYCLES cycles the FSM SHALL pulse timeout_err and return to IDLE.
REQ-022 In ARMED, a vote in the final timeout cycle SHALL win over the timeout.
REQ-023 In ARMED and CONFIRM, authorize and mode SHALL be ignored; mode is re-sampled in IDLE.
REQ-024 In CONFIRM, leds SHALL be 8'hFF for exactly CONFIRM_CYCLES cycles; all vote_valid SHALL be ignored; the FSM then SHALL go to IDLE.
REQ-025 In IDLE and ARMED, leds SHALL be 8'h00.
REQ-026 In RESULT, result_sel SHALL start at 0, advance after every DWELL_CYCLES cycles, and wrap from 3 to 0.
REQ-027 In RESULT, leds SHALL show the cand_counts slice for result_sel, one cycle behind result_sel.
REQ-028 In RESULT, when mode=0 the FSM SHALL go to IDLE the next cycle, clearing leds and result_sel.
REQ-029 In RESULT, vote_valid SHALL be ignored, with no reject_err.
REQ-030 Each timer SHALL count 0..N-1; N=1 SHALL mean a single cycle.

Reset
REQ-031 When reset=1, state SHALL be IDLE, the timer SHALL be 0, and vote_commit, ballot_armed, reject_err, timeout_err, result_sel and leds SHALL be 0 on the next edge.
REQ-032 Reset SHALL override all inputs, including mid-ARMED, mid-CONFIRM and mid-scan.
REQ-033 Reset SHALL discard a pending commit.

Structure
REQ-034 A shared package SHALL hold the state enumeration, the default values of the three parameters, and the candidate count (4) and tally width (8).
REQ-035 One sub-module, cycle_timer (load, enable, terminal-count output, width from the largest parameter), SHALL be reused for timeout, confirm and dwell.

Verification (TIMEOUT_CYCLES=20, CONFIRM_CYCLES=4, DWELL_CYCLES=3)
REQ-036 The bench SHALL cover: authorize, then vote_valid=4'b0010 three cycles later -> vote_commit=4'b0010 for one cycle, leds=8'hFF for 4 cycles, then IDLE.
REQ-037 The bench SHALL cover: authorize, then vote_valid=4'b0101 -> reject_err pulse, no commit, ballot_armed stays 1; a later 4'b1000 -> commit 4'b1000.
REQ-038 The bench SHALL cover: authorize, no votes -> timeout_err pulse 20 cycles after ARMED entry, ballot_armed=0; a vote in cycle 20 instead -> commit, no timeout_err.
REQ-039 The bench SHALL cover: cand_counts=32'h04_03_02_01, mode=1 in IDLE -> leds 01,01,01,02,02,02,03,03,03,04,04,04,01,...; mode=0 -> leds=0.
REQ-040 The bench SHALL cover: vote_valid=4'b0001 in IDLE -> reject_err, no commit; mode=1 during CONFIRM -> RESULT only after CONFIRM completes.
REQ-041 The bench SHALL cover: reset asserted mid-CONFIRM and mid-scan -> all outputs 0 the next cycle, state IDLE.
